// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: round-robin grant of the single Register_File write port
// among NUM_REQ requesters, plus a per-register busy scoreboard for ID-stage hazards.
module wb_port_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int WORD_WIDTH = 32,
    parameter int REG_ADDR_W = 4,
    parameter int REG_COUNT  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          alloc_en,
    input  logic [REG_ADDR_W-1:0]         alloc_dest,
    output logic                          alloc_stall,
    input  logic [REG_ADDR_W-1:0]         src1,
    input  logic [REG_ADDR_W-1:0]         src2,
    output logic                          hazard1,
    output logic                          hazard2,
    output logic                          WB_en,
    output logic [REG_ADDR_W-1:0]         WB_dest,
    output logic [WORD_WIDTH-1:0]         WB_result,
    output logic [REG_COUNT-1:0]          busy_vec
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 found;
    logic                 xfer;
    logic [REG_COUNT-1:0] busy_next;
    logic                 port_hit1;
    logic                 port_hit2;
    logic                 port_hit_alloc;

    // Handshake: requester i holds req_valid/dest/data stable until req_ready[i];
    // the write transfers on the posedge where both are high. req_ready is one-hot or 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        if (found && rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    // A write sitting on the port is committed on the negedge, before ID reads it.
    assign port_hit1      = WB_en && (WB_dest == src1);
    assign port_hit2      = WB_en && (WB_dest == src2);
    assign port_hit_alloc = WB_en && (WB_dest == alloc_dest);

    assign hazard1     = busy_vec[src1] && !port_hit1;
    assign hazard2     = busy_vec[src2] && !port_hit2;
    assign alloc_stall = alloc_en && busy_vec[alloc_dest] && !port_hit_alloc;

    // Clear before set so a new producer allocated in the retiring cycle stays busy.
    always_comb begin
        busy_next = busy_vec;
        if (WB_en) begin
            busy_next[WB_dest] = 1'b0;
        end
        if (alloc_en && !alloc_stall) begin
            busy_next[alloc_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_en     <= 1'b0;
            WB_dest   <= '0;
            WB_result <= '0;
            busy_vec  <= '0;
            rr_ptr    <= '0;
        end else begin
            busy_vec <= busy_next;
            if (xfer) begin
                WB_en     <= 1'b1;
                WB_dest   <= req_dest[grant_idx*REG_ADDR_W +: REG_ADDR_W];
                WB_result <= req_data[grant_idx*WORD_WIDTH +: WORD_WIDTH];
                rr_ptr    <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            end else begin
                WB_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: reset, single writes, round robin,
// scoreboard hazards, WAW stall/collision and idle behaviour.
module tb_wb_port_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_dest;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        alloc_en;
    logic [3:0]  alloc_dest;
    logic        alloc_stall;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard1;
    logic        hazard2;
    logic        WB_en;
    logic [3:0]  WB_dest;
    logic [31:0] WB_result;
    logic [15:0] busy_vec;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];

    wb_port_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready),
        .alloc_en(alloc_en), .alloc_dest(alloc_dest), .alloc_stall(alloc_stall),
        .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2),
        .WB_en(WB_en), .WB_dest(WB_dest), .WB_result(WB_result),
        .busy_vec(busy_vec)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [3:0] d0, input logic [31:0] x0,
                           input logic [3:0] d1, input logic [31:0] x1);
        req_valid = v;
        req_dest  = {d1, d0};
        req_data  = {x1, x0};
    endtask

    initial begin
        logic [3:0] exp_d;
        rst = 1'b0;
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        alloc_en = 1'b0; alloc_dest = '0; src1 = '0; src2 = 4'd6;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("reset_wb_en", {31'b0, WB_en}, 32'd0);
        check("reset_busy", {16'b0, busy_vec}, 32'd0);
        check("reset_ready", {30'b0, req_ready}, 32'd0);

        // single write from requester 0
        set_req(2'b01, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0);
        #1 check("single_ready", {30'b0, req_ready}, 32'd1);
        tick();
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        check("single_wb_en", {31'b0, WB_en}, 32'd1);
        check("single_wb_dest", {28'b0, WB_dest}, 32'd3);
        check("single_wb_result", WB_result, 32'hDEADBEEF);
        tick();
        check("single_wb_en_drop", {31'b0, WB_en}, 32'd0);
        check("idle_wb_dest_hold", {28'b0, WB_dest}, 32'd3);
        check("idle_wb_result_hold", WB_result, 32'hDEADBEEF);
        check("idle_ready", {30'b0, req_ready}, 32'd0);

        // pointer now 1: a lone requester 1 write brings it back to 0
        set_req(2'b10, 4'd0, 32'h0, 4'd9, 32'h11);
        #1 check("req1_ready", {30'b0, req_ready}, 32'd2);
        tick();
        check("req1_wb_dest", {28'b0, WB_dest}, 32'd9);
        check("req1_wb_result", WB_result, 32'h11);

        // round robin with both valid
        set_req(2'b11, 4'd1, 32'hA0, 4'd2, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_grant", {30'b0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            exp_q.push_back((i % 2 == 0) ? 4'd1 : 4'd2);
            tick();
            exp_d = exp_q.pop_front();
            check("rr_wb_en", {31'b0, WB_en}, 32'd1);
            check("rr_wb_dest", {28'b0, WB_dest}, {28'b0, exp_d});
        end
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);

        // scoreboard: allocate r5, watch hazard until its writeback reaches the port
        alloc_en = 1'b1; alloc_dest = 4'd5; src1 = 4'd5;
        #1 check("alloc5_stall", {31'b0, alloc_stall}, 32'd0);
        tick();
        alloc_en = 1'b0;
        #1 check("busy5_set", {16'b0, busy_vec}, 32'h0020);
        check("hazard1_set", {31'b0, hazard1}, 32'd1);
        check("hazard2_clear", {31'b0, hazard2}, 32'd0);
        tick();
        check("hazard1_hold", {31'b0, hazard1}, 32'd1);
        set_req(2'b01, 4'd5, 32'h55, 4'd0, 32'h0);
        tick();
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        check("wb5_on_port", {28'b0, WB_dest}, 32'd5);
        check("hazard1_bypass", {31'b0, hazard1}, 32'd0);
        check("busy5_still_set", {16'b0, busy_vec}, 32'h0020);
        tick();
        check("busy5_cleared", {16'b0, busy_vec}, 32'h0000);
        check("hazard1_after", {31'b0, hazard1}, 32'd0);

        // WAW stall and alloc in the retiring cycle
        alloc_en = 1'b1; alloc_dest = 4'd7; src1 = 4'd7;
        tick();
        #1 check("waw_stall", {31'b0, alloc_stall}, 32'd1);
        tick();
        check("waw_busy_unchanged", {16'b0, busy_vec}, 32'h0080);
        alloc_en = 1'b0;
        set_req(2'b10, 4'd0, 32'h0, 4'd7, 32'h77);
        #1 check("wb7_ready", {30'b0, req_ready}, 32'd2);
        tick();
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        alloc_en = 1'b1; alloc_dest = 4'd7;
        #1 check("collide_stall", {31'b0, alloc_stall}, 32'd0);
        check("collide_wb_dest", {28'b0, WB_dest}, 32'd7);
        tick();
        alloc_en = 1'b0;
        check("collide_busy_kept", {16'b0, busy_vec}, 32'h0080);
        check("collide_hazard1", {31'b0, hazard1}, 32'd1);
        check("collide_wb_en_drop", {31'b0, WB_en}, 32'd0);

        // idle cycles leave the pointer at 0
        repeat (3) tick();
        check("idle_wb_en", {31'b0, WB_en}, 32'd0);
        check("idle_wb_dest", {28'b0, WB_dest}, 32'd7);
        set_req(2'b11, 4'd10, 32'hC0, 4'd11, 32'hD0);
        #1 check("idle_ptr_kept", {30'b0, req_ready}, 32'd1);
        tick();
        check("pre_reset_wb_dest", {28'b0, WB_dest}, 32'd10);

        // asynchronous reset mid-transfer
        rst = 1'b0;
        #1;
        check("arst_wb_en", {31'b0, WB_en}, 32'd0);
        check("arst_wb_dest", {28'b0, WB_dest}, 32'd0);
        check("arst_wb_result", WB_result, 32'd0);
        check("arst_busy", {16'b0, busy_vec}, 32'd0);
        check("arst_ready", {30'b0, req_ready}, 32'd0);
        check("arst_hazard1", {31'b0, hazard1}, 32'd0);
        tick();
        rst = 1'b1;
        #1 check("post_reset_ptr", {30'b0, req_ready}, 32'd1);
        check("post_reset_busy", {16'b0, busy_vec}, 32'd0);
        tick();
        set_req(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        check("post_reset_wb_dest", {28'b0, WB_dest}, 32'd10);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
